c2_and_unit: RTL and testbench

Registered 8-bit operand unit combining three functions: two's complement (C2) of operand A, bitwise AND of A and B, and bytewise (logical) AND of A and B. It sits in the datapath as a single-cycle-latency execution slice. Operands, operation select and a valid strobe go in; a registered result, a valid strobe and optional status flags come out.

---
 rtl/c2_and_pkg.sv | 22 ++
 rtl/c2_and_core.sv | 34 +++
 rtl/c2_and_unit.sv | 69 ++++++
 tb/tb_c2_and_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/c2_and_pkg.sv
// Shared types and constants for the c2_and_unit execution slice.
package c2_and_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] C2_OVF_VAL = 8'h80;
    localparam logic [DATA_W-1:0] BYTE_TRUE  = 8'h01;

    typedef enum logic [1:0] {
        OP_C2       = 2'b00,
        OP_AND_BIT  = 2'b01,
        OP_AND_BYTE = 2'b10,
        OP_RSVD     = 2'b11
    } op_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/c2_and_core.sv
// Combinational datapath: next result and next status flags for one operation.
module c2_and_core
    import c2_and_pkg::*;
(
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_bin1,
    input  logic [DATA_W-1:0] i_bin2,
    output logic [DATA_W-1:0] o_result,
    output flags_t            o_flags
);

    logic [DATA_W-1:0] w_result;
    logic              w_ovf;

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (op_e'(i_op))
            OP_C2: begin
                w_result = ~i_bin1 + 8'd1;
                w_ovf    = (i_bin1 == C2_OVF_VAL);
            end
            OP_AND_BIT:  w_result = i_bin1 & i_bin2;
            OP_AND_BYTE: w_result = ((i_bin1 != '0) && (i_bin2 != '0)) ? BYTE_TRUE : '0;
            default:     w_result = '0;
        endcase
    end

    assign o_result     = w_result;
    assign o_flags.zero = (w_result == '0);
    assign o_flags.neg  = w_result[DATA_W-1];
    assign o_flags.ovf  = w_ovf;

endmodule

// File: rtl/c2_and_unit.sv
// Single-cycle registered C2 / bitwise AND / logical AND slice.
// Status flag registers are only built when C2AND_FLAGS_EN is defined.
module c2_and_unit
    import c2_and_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] bin1,
    input  logic [DATA_W-1:0] bin2,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_neg,
    output logic              flag_ovf
);

    logic [DATA_W-1:0] w_result;
    flags_t            w_flags;
    logic              r_valid;
    logic [DATA_W-1:0] r_result;

    c2_and_core u_core (
        .i_op     (op),
        .i_bin1   (bin1),
        .i_bin2   (bin2),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    // Result holds across idle cycles; only reset or a new valid op changes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_result <= w_result;
        end
    end

    assign out_valid = r_valid;
    assign result    = r_result;

`ifdef C2AND_FLAGS_EN
    flags_t r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (in_valid) begin
            r_flags <= w_flags;
        end
    end

    assign flag_zero = r_flags.zero;
    assign flag_neg  = r_flags.neg;
    assign flag_ovf  = r_flags.ovf;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^w_flags;

    assign flag_zero = 1'b0;
    assign flag_neg  = 1'b0;
    assign flag_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_c2_and_unit.sv
// Scoreboard bench for c2_and_unit; honours C2AND_FLAGS_EN like the design.
module tb_c2_and_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] op;
    logic [7:0] bin1;
    logic [7:0] bin2;
    logic       out_valid;
    logic [7:0] result;
    logic       flag_zero;
    logic       flag_neg;
    logic       flag_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected entry: {result[7:0], zero, neg, ovf}
    logic [10:0] exp_q[$];
    logic [10:0] hold_exp = '0;
    logic        mon_en   = 1'b0;

    c2_and_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .bin1      (bin1),
        .bin2      (bin2),
        .out_valid (out_valid),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .flag_ovf  (flag_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] model(input logic [1:0] o, input logic [7:0] a,
                                          input logic [7:0] b);
        int r;
        logic z, n, v;
        case (o)
            2'd0:    r = (256 - int'(a)) % 256;
            2'd1:    r = int'(a & b);
            2'd2:    r = (a != 0 && b != 0) ? 1 : 0;
            default: r = 0;
        endcase
        z = (r == 0);
        n = (r >= 128);
        v = (o == 2'd0) && (a == 8'd128);
`ifndef C2AND_FLAGS_EN
        z = 1'b0;
        n = 1'b0;
        v = 1'b0;
`endif
        return {r[7:0], z, n, v};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle; the model learns what the DUT sampled at that edge.
    task automatic drive(input logic rst, input logic v, input logic [1:0] o,
                         input logic [7:0] a, input logic [7:0] b);
        reset    = rst;
        in_valid = v;
        op       = o;
        bin1     = a;
        bin2     = b;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        if (rst) begin
            exp_q.delete();
            hold_exp = '0;
        end else if (v) begin
            exp_q.push_back(model(o, a, b));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'($urandom_range(0, 3)),
                                          8'($urandom), 8'($urandom));
    endtask

    // Monitor: one expected entry per cycle the DUT should present a result.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", int'(out_valid), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) hold_exp = exp_q.pop_front();
            check("result",    int'(result),    int'(hold_exp[10:3]));
            check("flag_zero", int'(flag_zero), int'(hold_exp[2]));
            check("flag_neg",  int'(flag_neg),  int'(hold_exp[1]));
            check("flag_ovf",  int'(flag_ovf),  int'(hold_exp[0]));
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b1; op = 2'd0; bin1 = 8'h12; bin2 = 8'h34;
        // Reset held two cycles with valid inputs present
        drive(1'b1, 1'b1, 2'd0, 8'hA5, 8'h00);
        drive(1'b1, 1'b1, 2'd1, 8'hFF, 8'hFF);

        drive(1'b0, 1'b1, 2'd0, 8'hA5, 8'h00);
        drive(1'b0, 1'b1, 2'd0, 8'h80, 8'h00);
        drive(1'b0, 1'b1, 2'd0, 8'h00, 8'hFF);
        idle(2);
        drive(1'b0, 1'b1, 2'd1, 8'hAA, 8'h0F);
        drive(1'b0, 1'b1, 2'd1, 8'hFF, 8'h80);
        drive(1'b0, 1'b1, 2'd2, 8'hAA, 8'h0F);
        drive(1'b0, 1'b1, 2'd2, 8'hAA, 8'h00);
        idle(1);

        // Back-to-back stream including the reserved op
        drive(1'b0, 1'b1, 2'd0, 8'h01, 8'h00);
        drive(1'b0, 1'b1, 2'd1, 8'hF0, 8'h3C);
        drive(1'b0, 1'b1, 2'd2, 8'h01, 8'h02);
        drive(1'b0, 1'b1, 2'd3, 8'h55, 8'hAA);
        idle(2);

        // Reset coinciding with a valid C2 input drops it; hold value returns to 0
        drive(1'b0, 1'b1, 2'd1, 8'hFF, 8'hC3);
        drive(1'b1, 1'b1, 2'd0, 8'h80, 8'h00);
        idle(2);

        // Valid C2 followed by reset the next cycle
        drive(1'b0, 1'b1, 2'd0, 8'h7F, 8'h00);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 8'h00;
            if ($urandom_range(0, 7) == 0) b = 8'h00;
            if ($urandom_range(0, 15) == 0) a = 8'h80;
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), a, b);
        end
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
